// File: rtl/sync_edge_filter_if.sv
// Bundle of the filter's data-side signals.
//   sig_b    : synchronized input level (master -> slave)
//   clr_cnt  : synchronous clear of the rise counter (master -> slave)
//   level_q  : deglitched level (slave -> master)
//   rise_p   : one-cycle pulse on accepted 0->1 (slave -> master)
//   fall_p   : one-cycle pulse on accepted 1->0 (slave -> master)
//   edge_cnt : saturating count of accepted rises (slave -> master)
//   cnt_sat  : high while edge_cnt is all-ones (slave -> master)
interface sync_edge_filter_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 sig_b;
    logic                 clr_cnt;
    logic                 level_q;
    logic                 rise_p;
    logic                 fall_p;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic                 cnt_sat;

    modport master (
        output sig_b, clr_cnt,
        input  level_q, rise_p, fall_p, edge_cnt, cnt_sat
    );

    modport slave (
        input  sig_b, clr_cnt,
        output level_q, rise_p, fall_p, edge_cnt, cnt_sat
    );
endinterface

// File: rtl/sync_edge_filter.sv
// Deglitching level filter with edge pulses and a saturating rise counter.
// A level change is accepted only after FILT_CYCLES consecutive equal samples.
//   clk_b : sole clock, rising edge
//   rst_b : synchronous, active-high reset
//   bus   : sync_edge_filter_if.slave (sig_b, clr_cnt in; level_q, rise_p,
//           fall_p, edge_cnt, cnt_sat out, all registered)
module sync_edge_filter #(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic              clk_b,
    input  logic              rst_b,
    sync_edge_filter_if.slave bus
);
    localparam int unsigned FW = 8;
    localparam logic [FW-1:0]        FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    state_t               state;
    logic [FW-1:0]        filt_cnt;
    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;
    logic [CNT_WIDTH-1:0] cnt_base_c;
    logic [CNT_WIDTH-1:0] cnt_next_c;

    // Clear first, then count the rise pulse currently on the output.
    always_comb begin
        cnt_base_c = bus.clr_cnt ? '0 : cnt;
        cnt_next_c = cnt_base_c;
        if (rise && (cnt_base_c != CNT_MAX)) begin
            cnt_next_c = cnt_base_c + CNT_WIDTH'(1);
        end
    end

    // Qualification FSM, pulses and rise counter.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            state    <= STABLE_LO;
            filt_cnt <= '0;
            level    <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            cnt      <= '0;
            sat      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (bus.sig_b) begin
                        // A one-sample filter accepts immediately.
                        if (FILT_CYCLES == 1) begin
                            state    <= STABLE_HI;
                            level    <= 1'b1;
                            rise     <= 1'b1;
                            filt_cnt <= '0;
                        end else begin
                            state    <= QUAL_HI;
                            filt_cnt <= FW'(1);
                        end
                    end
                end
                QUAL_HI: begin
                    if (!bus.sig_b) begin
                        state    <= STABLE_LO;
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILT_LAST) begin
                        state    <= STABLE_HI;
                        level    <= 1'b1;
                        rise     <= 1'b1;
                        filt_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + FW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!bus.sig_b) begin
                        if (FILT_CYCLES == 1) begin
                            state    <= STABLE_LO;
                            level    <= 1'b0;
                            fall     <= 1'b1;
                            filt_cnt <= '0;
                        end else begin
                            state    <= QUAL_LO;
                            filt_cnt <= FW'(1);
                        end
                    end
                end
                QUAL_LO: begin
                    if (bus.sig_b) begin
                        state    <= STABLE_HI;
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILT_LAST) begin
                        state    <= STABLE_LO;
                        level    <= 1'b0;
                        fall     <= 1'b1;
                        filt_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + FW'(1);
                    end
                end
                default: begin
                    state    <= STABLE_LO;
                    filt_cnt <= '0;
                    level    <= 1'b0;
                end
            endcase
            cnt <= cnt_next_c;
            sat <= (cnt_next_c == CNT_MAX);
        end
    end

    assign bus.level_q  = level;
    assign bus.rise_p   = rise;
    assign bus.fall_p   = fall;
    assign bus.edge_cnt = cnt;
    assign bus.cnt_sat  = sat;
endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter: dut_a (FILT_CYCLES=4, CNT_WIDTH=4) and
// dut_b (FILT_CYCLES=1, CNT_WIDTH=8) share stimulus; a timestamp-based
// reference model predicts both.
module tb_sync_edge_filter;
    logic clk = 1'b0;
    logic rst;
    logic sig;
    logic clr;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_edge_filter_if #(.CNT_WIDTH(4)) if_a ();
    sync_edge_filter_if #(.CNT_WIDTH(8)) if_b ();

    assign if_a.sig_b   = sig;
    assign if_a.clr_cnt = clr;
    assign if_b.sig_b   = sig;
    assign if_b.clr_cnt = clr;

    sync_edge_filter #(.FILT_CYCLES(4), .CNT_WIDTH(4)) dut_a (
        .clk_b (clk),
        .rst_b (rst),
        .bus   (if_a.slave)
    );

    sync_edge_filter #(.FILT_CYCLES(1), .CNT_WIDTH(8)) dut_b (
        .clk_b (clk),
        .rst_b (rst),
        .bus   (if_b.slave)
    );

    // Reference model: a level flips once FILT consecutive samples differ
    // from it, counted from the later of the last agreeing sample and the
    // last reset/flip (tracked as a cycle timestamp).
    int m_cyc = 0;
    int m_anchor [2];
    bit m_level [2];
    bit m_rise [2];
    bit m_fall [2];
    bit m_sat [2];
    int m_cnt [2];
    int m_f;
    int m_max;

    always @(posedge clk) begin
        m_cyc++;
        for (int i = 0; i < 2; i++) begin
            m_f   = (i == 0) ? 4 : 1;
            m_max = (i == 0) ? 15 : 255;
            if (rst) begin
                m_level[i]  = 1'b0;
                m_rise[i]   = 1'b0;
                m_fall[i]   = 1'b0;
                m_cnt[i]    = 0;
                m_anchor[i] = m_cyc;
            end else begin
                if (clr) m_cnt[i] = 0;
                if (m_rise[i] && m_cnt[i] < m_max) m_cnt[i] = m_cnt[i] + 1;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (sig == m_level[i]) begin
                    m_anchor[i] = m_cyc;
                end else if (m_cyc - m_anchor[i] >= m_f) begin
                    m_level[i]  = sig;
                    m_rise[i]   = sig;
                    m_fall[i]   = !sig;
                    m_anchor[i] = m_cyc;
                end
            end
            m_sat[i] = (m_cnt[i] == m_max);
        end
    end

    function automatic logic [7:0] obs_a();
        return {if_a.level_q, if_a.rise_p, if_a.fall_p, if_a.cnt_sat, if_a.edge_cnt};
    endfunction

    function automatic logic [11:0] obs_b();
        return {if_b.level_q, if_b.rise_p, if_b.fall_p, if_b.cnt_sat, if_b.edge_cnt};
    endfunction

    function automatic logic [7:0] mdl_a();
        return {m_level[0], m_rise[0], m_fall[0], m_sat[0], 4'(m_cnt[0])};
    endfunction

    function automatic logic [11:0] mdl_b();
        return {m_level[1], m_rise[1], m_fall[1], m_sat[1], 8'(m_cnt[1])};
    endfunction

    function automatic logic [7:0] pack_a(bit lv, bit r, bit f, bit s, int c);
        return {lv, r, f, s, 4'(c)};
    endfunction

    function automatic logic [11:0] pack_b(bit lv, bit r, bit f, bit s, int c);
        return {lv, r, f, s, 8'(c)};
    endfunction

    // Drive inputs, cross one rising edge, return at the falling edge.
    task automatic tick(input logic s, input logic c);
        sig = s;
        clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        n_cmp++;
        if (obs_a() !== 8'h00) begin
            n_err++;
            $display("FAIL reset_a got %b expected %b", obs_a(), 8'h00);
        end
        n_cmp++;
        if (obs_b() !== 12'h000) begin
            n_err++;
            $display("FAIL reset_b got %b expected %b", obs_b(), 12'h000);
        end
    endtask

    task automatic test_first_rise();
        rst = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick(1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== pack_a(t >= 4, t == 4, 1'b0, 1'b0, (t >= 5) ? 1 : 0)) begin
                n_err++;
                $display("FAIL first_rise_a edge %0d got %b expected %b", t, obs_a(),
                         pack_a(t >= 4, t == 4, 1'b0, 1'b0, (t >= 5) ? 1 : 0));
            end
            n_cmp++;
            if (obs_b() !== pack_b(1'b1, t == 1, 1'b0, 1'b0, (t >= 2) ? 1 : 0)) begin
                n_err++;
                $display("FAIL first_rise_b edge %0d got %b expected %b", t, obs_b(),
                         pack_b(1'b1, t == 1, 1'b0, 1'b0, (t >= 2) ? 1 : 0));
            end
        end
    endtask

    // Short dips and short pulses are rejected; interrupted runs restart.
    task automatic test_glitch();
        bit sigs [28] = '{0,0,0,1,1,0,0,0,0,0,1,1,1,0,1,1,1,0,1,1,1,1,1,0,0,0,0,0};
        bit lvls [28] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,0,0};
        logic [7:0] exp_v;
        for (int i = 0; i < 28; i++) begin
            tick(sigs[i], 1'b0);
            exp_v = pack_a(lvls[i], i == 21, (i == 8) || (i == 26), 1'b0, (i >= 22) ? 2 : 1);
            n_cmp++;
            if (obs_a() !== exp_v) begin
                n_err++;
                $display("FAIL glitch_a step %0d got %b expected %b", i, obs_a(), exp_v);
            end
            n_cmp++;
            if (obs_b() !== mdl_b()) begin
                n_err++;
                $display("FAIL glitch_b step %0d got %b expected %b", i, obs_b(), mdl_b());
            end
        end
    endtask

    // One-sample filter: output is the input delayed by one cycle.
    task automatic test_fast_filter();
        bit sigs [4] = '{0,1,1,0};
        logic [2:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            tick(sigs[i], 1'b0);
            exp_v = {sigs[i], i == 1, i == 3};
            n_cmp++;
            if ({if_b.level_q, if_b.rise_p, if_b.fall_p} !== exp_v) begin
                n_err++;
                $display("FAIL fast_filter_b step %0d got %b expected %b", i,
                         {if_b.level_q, if_b.rise_p, if_b.fall_p}, exp_v);
            end
            n_cmp++;
            if (if_b.edge_cnt !== 8'(m_cnt[1])) begin
                n_err++;
                $display("FAIL fast_filter_cnt step %0d got %0d expected %0d", i,
                         if_b.edge_cnt, m_cnt[1]);
            end
            n_cmp++;
            if (obs_a() !== pack_a(1'b0, 1'b0, 1'b0, 1'b0, 2)) begin
                n_err++;
                $display("FAIL fast_filter_a step %0d got %b expected %b", i, obs_a(),
                         pack_a(1'b0, 1'b0, 1'b0, 1'b0, 2));
            end
        end
    endtask

    task automatic test_saturation();
        int c;
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            c = (r - 1 > 15) ? 15 : r - 1;
            for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== pack_a(1'b1, 1'b1, 1'b0, c == 15, c)) begin
                n_err++;
                $display("FAIL sat_rise %0d got %b expected %b", r, obs_a(),
                         pack_a(1'b1, 1'b1, 1'b0, c == 15, c));
            end
            c = (r > 15) ? 15 : r;
            for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
            n_cmp++;
            if (obs_a() !== pack_a(1'b0, 1'b0, 1'b1, c == 15, c)) begin
                n_err++;
                $display("FAIL sat_count %0d got %b expected %b", r, obs_a(),
                         pack_a(1'b0, 1'b0, 1'b1, c == 15, c));
            end
        end
        tick(1'b0, 1'b1);
        n_cmp++;
        if (obs_a() !== pack_a(1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
            n_err++;
            $display("FAIL sat_clear got %b expected %b", obs_a(),
                     pack_a(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end
    endtask

    task automatic test_clr_coincident();
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
            for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
        n_cmp++;
        if (obs_a() !== pack_a(1'b1, 1'b1, 1'b0, 1'b0, 7)) begin
            n_err++;
            $display("FAIL clr_pre got %b expected %b", obs_a(), pack_a(1'b1, 1'b1, 1'b0, 1'b0, 7));
        end
        tick(1'b1, 1'b1);
        n_cmp++;
        if (obs_a() !== pack_a(1'b1, 1'b0, 1'b0, 1'b0, 1)) begin
            n_err++;
            $display("FAIL clr_with_rise got %b expected %b", obs_a(),
                     pack_a(1'b1, 1'b0, 1'b0, 1'b0, 1));
        end
        tick(1'b1, 1'b1);
        n_cmp++;
        if (obs_a() !== pack_a(1'b1, 1'b0, 1'b0, 1'b0, 0)) begin
            n_err++;
            $display("FAIL clr_level_kept got %b expected %b", obs_a(),
                     pack_a(1'b1, 1'b0, 1'b0, 1'b0, 0));
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
        n_cmp++;
        if (obs_a() !== pack_a(1'b0, 1'b0, 1'b1, 1'b0, 0)) begin
            n_err++;
            $display("FAIL clr_fall got %b expected %b", obs_a(), pack_a(1'b0, 1'b0, 1'b1, 1'b0, 0));
        end
    endtask

    // Reset in the middle of a qualification aborts it without a pulse.
    task automatic test_reset_abort();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        n_cmp++;
        if (obs_a() !== 8'h00) begin
            n_err++;
            $display("FAIL abort_reset_a got %b expected %b", obs_a(), 8'h00);
        end
        n_cmp++;
        if (obs_b() !== 12'h000) begin
            n_err++;
            $display("FAIL abort_reset_b got %b expected %b", obs_b(), 12'h000);
        end
        rst = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick(1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== pack_a(t >= 4, t == 4, 1'b0, 1'b0, (t >= 5) ? 1 : 0)) begin
                n_err++;
                $display("FAIL abort_requal edge %0d got %b expected %b", t, obs_a(),
                         pack_a(t >= 4, t == 4, 1'b0, 1'b0, (t >= 5) ? 1 : 0));
            end
        end
    endtask

    task automatic test_random();
        int  left = 0;
        logic v = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (left == 0) begin
                v    = 1'($urandom_range(0, 1));
                left = int'($urandom_range(1, 7));
            end
            left--;
            rst = ($urandom_range(0, 499) == 0);
            tick(v, $urandom_range(0, 199) == 0);
            n_cmp++;
            if (obs_a() !== mdl_a()) begin
                n_err++;
                $display("FAIL random_a cycle %0d got %b expected %b", c, obs_a(), mdl_a());
            end
            n_cmp++;
            if (obs_b() !== mdl_b()) begin
                n_err++;
                $display("FAIL random_b cycle %0d got %b expected %b", c, obs_b(), mdl_b());
            end
            n_cmp++;
            if ((if_a.rise_p & if_a.fall_p) !== 1'b0) begin
                n_err++;
                $display("FAIL random_excl cycle %0d got %b expected 0", c,
                         if_a.rise_p & if_a.fall_p);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sig = 1'b0;
        clr = 1'b0;
        test_reset();
        test_first_rise();
        test_glitch();
        test_fast_filter();
        test_saturation();
        test_clr_coincident();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sync_edge_filter.md
SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

Interface
REQ-001 The block SHALL have parameter FILT_CYCLES, default 4, giving the consecutive equal samples required to accept a level change (legal range 1..255).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the width of the qualified-rise event counter (legal range 2..32).
REQ-003 The block SHALL have port clk_b  input  1  sole clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst_b  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port sig_b  input  1  level already synchronized into clk_b domain by the upstream ff_sync stage.
REQ-006 The block SHALL have port clr_cnt  input  1  synchronous clear of edge_cnt and cnt_sat.
REQ-007 The block SHALL have port level_q  output  1  filtered (deglitched) level.
REQ-008 The block SHALL have port rise_p  output  1  one-cycle pulse on each accepted 0->1 change of level_q.
REQ-009 The block SHALL have port fall_p  output  1  one-cycle pulse on each accepted 1->0 change of level_q.
REQ-010 The block SHALL have port edge_cnt  output  CNT_WIDTH  count of accepted rising edges.
REQ-011 The block SHALL have port cnt_sat  output  1  high while edge_cnt is all-ones.

Function
REQ-012 The block SHALL implement a four-state FSM: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO; all outputs SHALL be registered.
REQ-013 STABLE_LO: sig_b=1 -> QUAL_HI with filter count 1; sig_b=0 -> stay.
REQ-014 QUAL_HI: sig_b=0 -> STABLE_LO, count cleared, no pulse (glitch rejected); sig_b=1 with count=FILT_CYCLES-1 -> STABLE_HI; otherwise count+1.
REQ-015 STABLE_HI/QUAL_LO SHALL mirror REQ-013/REQ-014 with sig_b polarity inverted.
REQ-016 Latency: if sig_b is first sampled high at edge k and stays high, level_q and rise_p SHALL go high after edge k+FILT_CYCLES-1; falling direction identical.
REQ-017 rise_p/fall_p SHALL be high for exactly one clk_b cycle per accepted transition and never simultaneously.
REQ-018 With FILT_CYCLES=1, QUAL states SHALL be skipped: level_q equals sig_b delayed one cycle, one pulse per sig_b transition.
REQ-019 A qualification interrupted by the opposite value on any sample SHALL restart; partial counts SHALL never carry over.
REQ-020 edge_cnt SHALL increment by 1 in the cycle rise_p is asserted and SHALL saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-021 cnt_sat SHALL be high in exactly the cycles edge_cnt equals all-ones.
REQ-022 clr_cnt SHALL zero edge_cnt next cycle; clr_cnt coincident with a rise SHALL yield edge_cnt=1 (clear, then count).
REQ-023 clr_cnt SHALL NOT affect FSM state, level_q or pulses.

Reset
REQ-024 While rst_b=1 at a clk_b edge: state STABLE_LO, filter count 0, level_q=0, rise_p=0, fall_p=0, edge_cnt=0, cnt_sat=0.
REQ-025 rst_b SHALL override clr_cnt and any in-progress qualification; no pulse SHALL be emitted for an aborted qualification.
REQ-026 If sig_b is high when rst_b deasserts, it SHALL qualify for FILT_CYCLES fresh samples and then produce a normal rise_p and count increment.

Verification
REQ-027 FILT_CYCLES=4: reset, sig_b=1 from edge 1 onward -> level_q=1, rise_p=1 after edge 4; rise_p=0 after edge 5; edge_cnt=1.
REQ-028 FILT_CYCLES=4: from STABLE_LO, sig_b high for 3 cycles then low -> level_q stays 0, no rise_p, edge_cnt unchanged; same for a 3-cycle low dip in STABLE_HI (no fall_p).
REQ-029 CNT_WIDTH=4: 16 qualified rises -> edge_cnt=15 with cnt_sat=1 from 15th rise on, remains 15 after 16th; then clr_cnt one cycle -> edge_cnt=0, cnt_sat=0.
REQ-030 clr_cnt asserted in the same cycle rise_p asserts with edge_cnt=7 -> edge_cnt=1 next cycle.
REQ-031 FILT_CYCLES=4: rst_b pulsed after 2 high samples in QUAL_HI, sig_b held high -> all outputs 0 during reset, level_q rises only after 4 post-reset samples, single rise_p.
REQ-032 FILT_CYCLES=1: sig_b toggles 0,1,1,0 on edges 1-4 -> level_q 0,1,1,0 one cycle later; rise_p after edge 2, fall_p after edge 4.
